// File: rtl/instruction_loader.sv
// Streams a program into the 128 x 16 instruction memory, pads the tail with HALT,
// and holds the CPU controller in reset until the image is complete.
module instruction_loader #(
  parameter int              ADDR_W    = 7,
  parameter int              DEPTH     = 2 ** ADDR_W,
  parameter logic [15:0]     HALT_WORD = 16'h5000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              im_wr_en,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wr_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   WC_MAX    = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FILL,
    DRAIN,
    RUN,
    ERR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              overflow_q;
  logic              accept;
  logic              at_top;
  logic              load_write;

  assign at_top     = (addr == LAST_ADDR);
  assign in_ready   = (state == LOAD) || (state == DRAIN);
  assign accept     = in_valid && in_ready;
  assign load_write = (state == LOAD) && accept;
  assign im_wr_en   = load_write || (state == FILL);
  assign im_addr    = addr;
  assign cpu_reset  = (state != RUN);
  assign done       = (state == RUN);
  assign overflow   = overflow_q;

  // Source words pass straight through to the memory on the cycle they are accepted.
  always_comb begin
    im_wr_data = '0;
    if (load_write) begin
      im_wr_data = in_data;
    end else if (state == FILL) begin
      im_wr_data = HALT_WORD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      word_count <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN, ERR: begin
          if (start) begin
            state      <= LOAD;
            addr       <= '0;
            word_count <= '0;
            overflow_q <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            addr       <= addr + ADDR_W'(1);
            word_count <= word_count + (ADDR_W + 1)'(1);
            if (in_last) begin
              state <= at_top ? RUN : FILL;
            end else if (at_top) begin
              // Memory is full but the source keeps going: swallow the rest of the stream.
              state      <= DRAIN;
              overflow_q <= 1'b1;
            end
          end
        end
        FILL: begin
          addr <= addr + ADDR_W'(1);
          if (at_top) begin
            state <= RUN;
          end
        end
        DRAIN: begin
          if (accept) begin
            if (word_count != WC_MAX) begin
              word_count <= word_count + (ADDR_W + 1)'(1);
            end
            if (in_last) begin
              state <= ERR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed testbench for instruction_loader: models the instruction memory and
// checks images, latencies, overflow handling and reset behaviour.
module tb_instruction_loader;

  localparam logic [15:0] HALT = 16'h5000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        im_wr_en;
  logic [6:0]  im_addr;
  logic [15:0] im_wr_data;
  logic        cpu_reset;
  logic        done;
  logic        overflow;
  logic [7:0]  word_count;

  logic [15:0] mem  [0:127];
  logic [15:0] prog [0:127];
  logic        clear_req;
  int          tests_run = 0;
  int          failures  = 0;
  int          cyc       = 0;
  int          t0        = 0;

  instruction_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .im_wr_en   (im_wr_en),
    .im_addr    (im_addr),
    .im_wr_data (im_wr_data),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural instruction memory; a clear request poisons it so stale words show up.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clear_req) begin
      for (int i = 0; i < 128; i++) mem[i] <= 16'hDEAD;
    end else if (im_wr_en) begin
      mem[im_addr] <= im_wr_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clearModel();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
  endtask

  task automatic loadProgram(input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) t0 = cyc;
      applyStimulus(1'b1, prog[i], (i == n - 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int exp_edges);
    int b;
    b = 0;
    while (done !== 1'b1 && b < 400) begin
      @(negedge clk);
      b++;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cyc - t0), 32'(exp_edges));
    checkOutput({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
  endtask

  task automatic checkImage(input string tag, input int n);
    for (int i = 0; i < 128; i++) begin
      checkOutput($sformatf("%s[%0d]", tag, i), 32'(mem[i]), (i < n) ? 32'(prog[i]) : 32'(HALT));
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_im_wr_en", 32'(im_wr_en), 32'd0);
    checkOutput("rst_im_addr", 32'(im_addr), 32'd0);
    checkOutput("rst_im_wr_data", 32'(im_wr_data), 32'd0);
    checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd0);

    // Three-word program, back to back
    pulseStart();
    checkOutput("p3_in_ready", 32'(in_ready), 32'd1);
    checkOutput("p3_cpu_reset_load", 32'(cpu_reset), 32'd1);
    prog[0] = 16'h2104;
    prog[1] = 16'h2215;
    prog[2] = 16'h3126;
    t0       = cyc;
    in_valid = 1'b1;
    in_data  = prog[0];
    in_last  = 1'b0;
    #1;
    checkOutput("p3_first_wr_en", 32'(im_wr_en), 32'd1);
    checkOutput("p3_first_addr", 32'(im_addr), 32'd0);
    checkOutput("p3_first_data", 32'(im_wr_data), 32'h2104);
    @(negedge clk);
    applyStimulus(1'b1, prog[1], 1'b0);
    applyStimulus(1'b1, prog[2], 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("p3_fill_wr_en", 32'(im_wr_en), 32'd1);
    checkOutput("p3_fill_data", 32'(im_wr_data), 32'(HALT));
    waitDone("p3", 128);
    checkOutput("p3_word_count", 32'(word_count), 32'd3);
    checkOutput("p3_run_wr_en", 32'(im_wr_en), 32'd0);
    checkImage("p3_mem", 3);

    // Same program with two-cycle valid gaps
    clearModel();
    pulseStart();
    t0 = cyc;
    applyStimulus(1'b1, prog[0], 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0);
    checkOutput("gap_wr_en", 32'(im_wr_en), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("gap_last_no_effect_wr_en", 32'(im_wr_en), 32'd0);
    applyStimulus(1'b1, prog[1], 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0);
    applyStimulus(1'b1, prog[2], 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    waitDone("gap", 132);
    checkOutput("gap_word_count", 32'(word_count), 32'd3);
    checkImage("gap_mem", 3);

    // Exactly DEPTH words: no fill phase
    clearModel();
    pulseStart();
    for (int i = 0; i < 128; i++) prog[i] = 16'h1000 + 16'(i);
    loadProgram(128);
    checkOutput("full_done_immediate", 32'(done), 32'd1);
    checkOutput("full_latency", 32'(cyc - t0), 32'd128);
    checkOutput("full_word_count", 32'(word_count), 32'd128);
    checkOutput("full_overflow", 32'(overflow), 32'd0);
    checkImage("full_mem", 128);

    // 130 words: last two dropped, error state
    clearModel();
    pulseStart();
    for (int i = 0; i < 130; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hA000 + 16'(i);
      in_last  = (i == 129);
      if (i == 128) begin
        #1;
        checkOutput("ovf_drain_wr_en", 32'(im_wr_en), 32'd0);
        checkOutput("ovf_drain_in_ready", 32'(in_ready), 32'd1);
        checkOutput("ovf_drain_overflow", 32'(overflow), 32'd1);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("ovf_overflow", 32'(overflow), 32'd1);
    checkOutput("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("ovf_done", 32'(done), 32'd0);
    checkOutput("ovf_word_count", 32'(word_count), 32'd128);
    checkOutput("ovf_mem0", 32'(mem[0]), 32'hA000);
    checkOutput("ovf_mem127", 32'(mem[127]), 32'hA07F);
    repeat (3) @(negedge clk);
    checkOutput("ovf_err_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("ovf_err_overflow", 32'(overflow), 32'd1);
    checkOutput("ovf_err_in_ready", 32'(in_ready), 32'd0);
    pulseStart();
    checkOutput("ovf_reload_overflow", 32'(overflow), 32'd0);
    checkOutput("ovf_reload_word_count", 32'(word_count), 32'd0);
    prog[0] = 16'h7777;
    loadProgram(1);
    waitDone("ovf_reload", 128);
    checkOutput("ovf_reload_overflow_run", 32'(overflow), 32'd0);
    checkOutput("ovf_reload_mem0", 32'(mem[0]), 32'h7777);
    checkOutput("ovf_reload_mem1", 32'(mem[1]), 32'(HALT));

    // Restart from RUN with a single NOP word
    clearModel();
    pulseStart();
    checkOutput("rerun_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("rerun_done", 32'(done), 32'd0);
    prog[0] = 16'h0000;
    loadProgram(1);
    waitDone("rerun", 128);
    checkImage("rerun_mem", 1);

    // Asynchronous reset in the middle of the fill phase
    pulseStart();
    for (int i = 0; i < 5; i++) prog[i] = 16'hC000 + 16'(i);
    loadProgram(5);
    begin
      int b;
      b = 0;
      while (im_addr !== 7'd40 && b < 200) begin
        @(negedge clk);
        b++;
      end
    end
    checkOutput("mid_fill_addr", 32'(im_addr), 32'd40);
    checkOutput("mid_fill_wr_en", 32'(im_wr_en), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_rst_im_wr_en", 32'(im_wr_en), 32'd0);
    checkOutput("mid_rst_im_addr", 32'(im_addr), 32'd0);
    checkOutput("mid_rst_im_wr_data", 32'(im_wr_data), 32'd0);
    checkOutput("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    checkOutput("mid_rst_word_count", 32'(word_count), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("post_rst_wr_en", 32'(im_wr_en), 32'd0);
      checkOutput("post_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    pulseStart();
    checkOutput("post_rst_start_in_ready", 32'(in_ready), 32'd1);
    prog[0] = 16'h0ABC;
    loadProgram(1);
    waitDone("post_rst", 128);
    checkOutput("post_rst_word_count", 32'(word_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
